// File: rtl/cal_pkg.sv
// Shared types and helpers for the per-channel offset/gain calibration engine.
package cal_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_MUL,
        ST_STORE,
        ST_COMMIT
    } state_e;

    function automatic int unsigned unity_gain(input int unsigned frac);
        return 32'd1 << frac;
    endfunction

    // Clamp a signed value into the range of a w-bit two's-complement word.
    function automatic logic signed [63:0] sat_s(input logic signed [63:0] v,
                                                 input int unsigned        w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/cal_mac.sv
// Registered calibration datapath: operands latched in LOAD, product latched in MUL,
// shift and saturation resolved combinationally for the STORE cycle.
module cal_mac
    import cal_pkg::*;
#(
    parameter int W         = 16,
    parameter int GAIN_W    = 16,
    parameter int GAIN_FRAC = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              mul_i,
    input  logic [W-1:0]      x_i,
    input  logic [W-1:0]      offset_i,
    input  logic [GAIN_W-1:0] gain_i,
    output logic [W-1:0]      res_o,
    output logic              sat_o
);

    localparam int PW = W + 1 + GAIN_W;

    logic signed [W-1:0]      x_q;
    logic signed [W-1:0]      off_q;
    logic signed [GAIN_W-1:0] gain_q;
    logic signed [PW-1:0]     p_q;

    logic signed [W:0]        diff;
    logic signed [PW-1:0]     p_d;
    logic signed [63:0]       r;
    logic signed [63:0]       r_sat;

    // NOTE: state is updated with <= so every register samples pre-edge values;
    // blocking assignments here would make the result depend on statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_q    <= '0;
            off_q  <= '0;
            gain_q <= '0;
            p_q    <= '0;
        end else begin
            if (load_i) begin
                x_q    <= x_i;
                off_q  <= offset_i;
                gain_q <= gain_i;
            end
            if (mul_i) p_q <= p_d;
        end
    end

    always_comb begin
        diff  = {x_q[W-1], x_q} - {off_q[W-1], off_q};
        p_d   = PW'(diff) * PW'(gain_q);
        r     = 64'(p_q >>> GAIN_FRAC);
        r_sat = sat_s(r, W);
        res_o = r_sat[W-1:0];
        sat_o = (r_sat != r);
    end

endmodule

// File: rtl/cal_engine.sv
// Frame-based calibration engine: snapshots all channels on a sample_clk rising edge,
// applies (x - offset) * gain per channel through cal_mac, then commits atomically.
module cal_engine
    import cal_pkg::*;
#(
    parameter int              W         = 16,
    parameter int              N_CH      = 8,
    parameter int              GAIN_W    = 16,
    parameter int              GAIN_FRAC = 14,
    parameter logic [N_CH-1:0] MUTE_MASK = '0,
    localparam int             AW        = $clog2(N_CH),
    localparam int             DW        = (W > GAIN_W) ? W : GAIN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_clk,
    input  logic [N_CH*W-1:0] in_flat,
    input  logic [N_CH-1:0]   jack,
    input  logic              cal_we,
    input  logic [AW-1:0]     cal_addr,
    input  logic              cal_sel,
    input  logic [DW-1:0]     cal_wdata,
    output logic [N_CH*W-1:0] out_flat,
    output logic              busy,
    output logic              done,
    output logic [N_CH-1:0]   clip,
    output logic              overrun
);

    state_e            state_q, state_d;
    logic [AW-1:0]     ch_q, ch_d;
    logic              sc_q;
    logic              rise;

    logic [W-1:0]      x_snap_q   [N_CH];
    logic [N_CH-1:0]   jack_snap_q;
    logic [W-1:0]      offset_q   [N_CH];
    logic [GAIN_W-1:0] gain_q     [N_CH];
    logic [W-1:0]      shadow_q   [N_CH];
    logic [N_CH*W-1:0] out_q;
    logic              done_q;
    logic [N_CH-1:0]   clip_q;
    logic              overrun_q;

    logic [W-1:0]      mac_res;
    logic              mac_sat;
    logic              muted;

    assign rise  = sample_clk & ~sc_q;
    assign muted = MUTE_MASK[ch_q] & ~jack_snap_q[ch_q];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            ch_q    <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        unique case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    state_d = ST_LOAD;
                    ch_d    = '0;
                end
            end
            ST_LOAD:  state_d = ST_MUL;
            ST_MUL:   state_d = ST_STORE;
            ST_STORE: begin
                if (ch_q == AW'(N_CH - 1)) begin
                    state_d = ST_COMMIT;
                end else begin
                    state_d = ST_LOAD;
                    ch_d    = ch_q + AW'(1);
                end
            end
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // NOTE: the sample and coefficient arrays are cleared in reset because their
    // contents are visible afterwards through out_flat and the next frame's results.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sc_q        <= 1'b0;
            jack_snap_q <= '0;
            clip_q      <= '0;
            overrun_q   <= 1'b0;
            done_q      <= 1'b0;
            out_q       <= '0;
            for (int k = 0; k < N_CH; k++) begin
                x_snap_q[k] <= '0;
                shadow_q[k] <= '0;
            end
        end else begin
            sc_q   <= sample_clk;
            done_q <= (state_q == ST_COMMIT);
            if (rise && state_q != ST_IDLE) overrun_q <= 1'b1;
            if (rise && state_q == ST_IDLE) begin
                for (int k = 0; k < N_CH; k++) x_snap_q[k] <= in_flat[k*W +: W];
                jack_snap_q <= jack;
            end
            if (state_q == ST_STORE) begin
                shadow_q[ch_q] <= muted ? '0 : mac_res;
                if (mac_sat && !muted) clip_q[ch_q] <= 1'b1;
            end
            if (state_q == ST_COMMIT) begin
                for (int k = 0; k < N_CH; k++) out_q[k*W +: W] <= shadow_q[k];
            end
        end
    end

    // A write coinciding with LOAD of the same channel lands after LOAD has sampled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < N_CH; k++) begin
                offset_q[k] <= '0;
                gain_q[k]   <= GAIN_W'(unity_gain(GAIN_FRAC));
            end
        end else if (cal_we && (int'(cal_addr) < N_CH)) begin
            if (cal_sel) gain_q[cal_addr]   <= cal_wdata[GAIN_W-1:0];
            else         offset_q[cal_addr] <= cal_wdata[W-1:0];
        end
    end

    cal_mac #(
        .W         (W),
        .GAIN_W    (GAIN_W),
        .GAIN_FRAC (GAIN_FRAC)
    ) u_mac (
        .clk      (clk),
        .rst      (rst),
        .load_i   (state_q == ST_LOAD),
        .mul_i    (state_q == ST_MUL),
        .x_i      (x_snap_q[ch_q]),
        .offset_i (offset_q[ch_q]),
        .gain_i   (gain_q[ch_q]),
        .res_o    (mac_res),
        .sat_o    (mac_sat)
    );

    assign out_flat = out_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign clip     = clip_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_cal_engine.sv
// Directed bench for cal_engine: defaults, offset/gain math, saturation, muting,
// overrun with mid-frame coefficient writes, and mid-frame reset.
module tb_cal_engine;

    localparam int W         = 16;
    localparam int N_CH      = 8;
    localparam int GAIN_W    = 16;
    localparam int GAIN_FRAC = 14;
    localparam int LAT       = 3 * N_CH + 2;

    logic              clk        = 1'b0;
    logic              rst        = 1'b0;
    logic              sample_clk = 1'b0;
    logic [N_CH*W-1:0] in_flat    = '0;
    logic [N_CH-1:0]   jack       = '1;
    logic              cal_we     = 1'b0;
    logic [2:0]        cal_addr   = '0;
    logic              cal_sel    = 1'b0;
    logic [15:0]       cal_wdata  = '0;
    logic [N_CH*W-1:0] out_flat;
    logic              busy;
    logic              done;
    logic [N_CH-1:0]   clip;
    logic              overrun;

    int checks = 0;
    int errors = 0;

    cal_engine #(
        .W         (W),
        .N_CH      (N_CH),
        .GAIN_W    (GAIN_W),
        .GAIN_FRAC (GAIN_FRAC),
        .MUTE_MASK (8'h01)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sample_clk (sample_clk),
        .in_flat    (in_flat),
        .jack       (jack),
        .cal_we     (cal_we),
        .cal_addr   (cal_addr),
        .cal_sel    (cal_sel),
        .cal_wdata  (cal_wdata),
        .out_flat   (out_flat),
        .busy       (busy),
        .done       (done),
        .clip       (clip),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_ch(input string tag, input int k, input int exp);
        logic [W-1:0] e;
        logic [W-1:0] o;
        e = W'(exp);
        o = out_flat[k*W +: W];
        check(tag, 64'(o), 64'(e));
    endtask

    task automatic set_in(input int k, input int v);
        in_flat[k*W +: W] = W'(v);
    endtask

    task automatic cal_write(input logic sel, input int addr, input int data);
        @(negedge clk);
        cal_we    = 1'b1;
        cal_sel   = sel;
        cal_addr  = 3'(addr);
        cal_wdata = 16'(data);
        @(negedge clk);
        cal_we    = 1'b0;
    endtask

    // Raise sample_clk mid-cycle and count clk edges until done is seen (bounded).
    task automatic run_frame(output int lat);
        lat = -1;
        @(negedge clk);
        sample_clk = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            #1;
            if (n == 2) sample_clk = 1'b0;
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int ndone;

        // Reset state
        #1;
        check("rst_out", 64'(out_flat), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_clip", 64'(clip), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Default coefficients, latency and done pulse
        set_in(0, 1000);
        run_frame(lat);
        check("lat_a", 64'(lat), 64'(LAT));
        check_ch("a_ch0", 0, 1000);
        check("a_busy_after", 64'(busy), 64'd0);
        @(posedge clk); #1;
        check("a_done_pulse", 64'(done), 64'd0);

        // Offset + gain, saturation, floor rounding
        cal_write(1'b0, 1, 200);
        cal_write(1'b1, 1, 24576);
        cal_write(1'b1, 2, 32767);
        cal_write(1'b1, 3, 24576);
        set_in(1, 1200);
        set_in(2, 20000);
        set_in(3, -3);
        run_frame(lat);
        check("lat_b", 64'(lat), 64'(LAT));
        check_ch("b_ch1", 1, 1500);
        check_ch("b_ch2_sat", 2, 32767);
        check_ch("b_ch3_floor", 3, -5);
        check("b_clip", 64'(clip), 64'h04);

        // Negative paths, negative saturation, offset-subtract overflow
        cal_write(1'b0, 1, 0);
        cal_write(1'b1, 1, 16384);
        cal_write(1'b0, 4, 32767);
        set_in(1, -3);
        set_in(2, -20000);
        set_in(4, -32768);
        run_frame(lat);
        check_ch("c_ch1", 1, -3);
        check_ch("c_ch2_sat", 2, -32768);
        check_ch("c_ch4_sat", 4, -32768);
        check("c_clip", 64'(clip), 64'h14);

        // Muted channel: zero output, no clip even when it would saturate
        cal_write(1'b1, 0, 32767);
        jack = 8'hFE;
        set_in(0, 20000);
        run_frame(lat);
        check_ch("mute_ch0", 0, 0);
        check("mute_clip", 64'(clip), 64'h14);
        cal_write(1'b1, 0, 16384);
        jack = 8'hFF;
        set_in(0, 5000);
        run_frame(lat);
        check_ch("unmute_ch0", 0, 5000);

        // Overrun and mid-frame coefficient writes
        check("pre_overrun", 64'(overrun), 64'd0);
        set_in(0, 1000);
        set_in(7, 1000);
        lat   = -1;
        ndone = 0;
        @(negedge clk);
        sample_clk = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                if (lat < 0) lat = n;
            end
            if (n == 2) sample_clk = 1'b0;
            if (n == 5) begin
                sample_clk = 1'b1;
                set_in(0, 3000);
                set_in(7, 3000);
                cal_we     = 1'b1;
                cal_sel    = 1'b1;
                cal_addr   = 3'd7;
                cal_wdata  = 16'd8192;
            end
            if (n == 6) begin
                cal_addr  = 3'd0;
                cal_wdata = 16'd32767;
            end
            if (n == 7) begin
                cal_we     = 1'b0;
                sample_clk = 1'b0;
            end
            if (n == 25) check_ch("no_partial", 0, 5000);
        end
        check("ovr_flag", 64'(overrun), 64'd1);
        check("ovr_lat", 64'(lat), 64'(LAT));
        check("ovr_ndone", 64'(ndone), 64'd1);
        check_ch("ovr_ch0_oldgain", 0, 1000);
        check_ch("ovr_ch7_newgain", 7, 500);

        // Reset mid-frame aborts; defaults restored
        ndone = 0;
        @(negedge clk);
        sample_clk = 1'b1;
        for (int n = 1; n <= 50; n++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
            if (n == 2)  sample_clk = 1'b0;
            if (n == 10) rst = 1'b0;
            if (n == 11) rst = 1'b1;
        end
        check("rst_ndone", 64'(ndone), 64'd0);
        check("rst_mid_out", 64'(out_flat), 64'd0);
        check("rst_mid_clip", 64'(clip), 64'd0);
        check("rst_mid_overrun", 64'(overrun), 64'd0);
        in_flat = '0;
        set_in(0, 1000);
        set_in(1, 1200);
        set_in(4, -32768);
        set_in(7, 1000);
        run_frame(lat);
        check("lat_d", 64'(lat), 64'(LAT));
        check_ch("d_ch0", 0, 1000);
        check_ch("d_ch1_defoff", 1, 1200);
        check_ch("d_ch4_defoff", 4, -32768);
        check_ch("d_ch7_defgain", 7, 1000);
        check("d_clip", 64'(clip), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cal_engine.md
CAL_ENGINE -- requirements
Module: cal_engine

Interface
REQ-001 Parameter W, 16, sample width in bits (signed two's complement).
REQ-002 Parameter N_CH, 8, number of channels; must be at least 2.
REQ-003 Parameter GAIN_W, 16, width of the signed gain coefficient.
REQ-004 Parameter GAIN_FRAC, 14, number of fractional bits in gain; unity gain = 2^GAIN_FRAC.
REQ-005 Parameter MUTE_MASK, {N_CH{1'b0}}, per-channel enable for jack-based muting.
REQ-006 clk  in  1  system clock; the only clock.
REQ-007 rst  in  1  asynchronous, active-low reset.
REQ-008 sample_clk  in  1  codec frame strobe, level signal synchronous to clk; a frame starts on each rising edge.
REQ-009 in_flat  in  N_CH*W  raw samples; channel k occupies bits [k*W +: W].
REQ-010 jack  in  N_CH  jack-inserted flags, 1 = plugged.
REQ-011 cal_we  in  1  coefficient write strobe, single-cycle.
REQ-012 cal_addr  in  $clog2(N_CH)  channel index for the coefficient write.
REQ-013 cal_sel  in  1  target select: 0 = offset (low W bits of cal_wdata), 1 = gain.
REQ-014 cal_wdata  in  max(W,GAIN_W)  coefficient write data.
REQ-015 out_flat  out  N_CH*W  calibrated samples, same packing as in_flat.
REQ-016 busy  out  1  high while a frame is being processed.
REQ-017 done  out  1  one-cycle pulse when out_flat updates.
REQ-018 clip  out  N_CH  sticky saturation flags, one per channel.
REQ-019 overrun  out  1  sticky flag: a frame started while busy.

Function
REQ-020 A rising edge of sample_clk (registered value 0 -> 1) while idle shall latch in_flat and jack into snapshot registers and enter LOAD.
REQ-021 The FSM shall step IDLE -> LOAD -> MUL -> STORE per channel, channel 0 first; after STORE of channel N_CH-1 it enters COMMIT, then returns to IDLE.
REQ-022 In LOAD, the engine shall read the channel's offset and gain from the coefficient registers.
REQ-023 In MUL, it shall compute d = sext(x) - sext(offset) at W+1 bits and p = d * gain as a signed product.
REQ-024 In STORE, it shall compute r = p >>> GAIN_FRAC (arithmetic shift, floor), saturate r to [-2^(W-1), 2^(W-1)-1], and write r to a shadow register.
REQ-025 If saturation occurs, the engine shall set clip[k], which stays set until reset.
REQ-026 If MUTE_MASK[k]=1 and the snapshot jack[k]=0, STORE shall write 0 and shall not set clip[k].
REQ-027 In COMMIT, the engine shall copy all shadow registers to out_flat in a single cycle and assert done for that one cycle.
REQ-028 Latency from the sample_clk edge cycle to done shall be exactly 3*N_CH+2 clk cycles; out_flat shall never show a partially updated frame.
REQ-029 busy shall be high in every state except IDLE.
REQ-030 A sample_clk rising edge while busy shall be ignored, set overrun, and leave the current frame unaffected.
REQ-031 cal_we shall update the addressed coefficient on the next clk edge, including while busy.
REQ-032 A channel already past LOAD in the current frame shall use its old coefficient value; the new value applies from the next LOAD of that channel.
REQ-033 A cal_addr value of N_CH or more shall be ignored.
REQ-034 Simultaneous cal_we and LOAD on the same channel shall give LOAD the pre-write value.

Reset
REQ-035 On reset: out_flat = 0, shadow registers = 0, all offsets = 0, all gains = 2^GAIN_FRAC, clip = 0, overrun = 0, busy = 0, done = 0, FSM = IDLE, registered sample_clk = 0.
REQ-036 Reset asserted mid-frame shall abort the frame with no commit; the first rising edge of sample_clk after release starts a fresh frame.

Structure
REQ-037 A shared package cal_pkg shall hold the FSM state enum, the unity-gain constant function, and the saturation helper function.
REQ-038 One sub-module, cal_mac, shall hold the registered subtract/multiply/shift/saturate datapath and output a saturation flag.

Verification (W=16, N_CH=8, GAIN_FRAC=14)
REQ-039 Scenario: after reset, ch0=1000, defaults, one edge -> out ch0=1000, done exactly 26 cycles after the edge cycle.
REQ-040 Scenario: ch1: offset=200, gain=24576, in=1200 -> out=1500; in=-3 with offset=0 and gain=16384 -> out=-3.
REQ-041 Scenario: ch2: gain=32767, in=20000 -> out=32767 and clip[2]=1; in=-20000 -> out=-32768.
REQ-042 Scenario: MUTE_MASK=8'h01, jack[0]=0, in=5000 -> out ch0=0 and clip[0]=0; with jack[0]=1 -> out=5000.
REQ-043 Scenario: second edge 5 cycles into a frame -> overrun=1, single done, outputs from the first snapshot; gain write to ch7 mid-frame -> ch7 uses the new gain, ch0 uses the old gain.
REQ-044 Scenario: reset pulsed at cycle 10 of a frame -> no done, out_flat=0, coefficients back to defaults.
